// File: rtl/ecall_write_sequencer.sv
// Write-ecall sequencer: streams len bytes from memory port 2
// to an external byte link under a valid/ready handshake.
module ecall_write_sequencer #(
   parameter int                ADDR_W  = 32,
   parameter logic [ADDR_W-1:0] FD_MASK = ADDR_W'(6)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              write_ecall,
   input  logic [ADDR_W-1:0] write_ecall_fd,
   input  logic [ADDR_W-1:0] write_ecall_addr,
   input  logic [ADDR_W-1:0] write_ecall_len,
   output logic              finished,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rd_data,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              bad_fd,
   output logic [ADDR_W-1:0] bytes_sent
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_SEND,
      S_DONE
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] len_q;
   logic [ADDR_W-1:0] off_q;
   logic [ADDR_W-1:0] sent_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        txd_q;
   logic              txv_q;
   logic              fin_q;
   logic              rd_en_q;
   logic              bad_q;

   logic [ADDR_W-1:0] off_d;
   logic              fd_ok;

   // fds at or beyond ADDR_W shift out to zero and are rejected
   assign fd_ok = |(FD_MASK & (ADDR_W'(1) << write_ecall_fd));
   assign off_d = off_q + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         len_q   <= '0;
         off_q   <= '0;
         sent_q  <= '0;
         addr_q  <= '0;
         txd_q   <= '0;
         txv_q   <= 1'b0;
         fin_q   <= 1'b1;
         rd_en_q <= 1'b0;
         bad_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               fin_q <= 1'b1;
               if (write_ecall) begin
                  base_q <= write_ecall_addr;
                  len_q  <= write_ecall_len;
                  off_q  <= '0;
                  sent_q <= '0;
                  fin_q  <= 1'b0;
                  if (!fd_ok) begin
                     bad_q   <= 1'b1;
                     state_q <= S_DONE;
                  end else if (write_ecall_len == '0) begin
                     state_q <= S_DONE;
                  end else begin
                     rd_en_q <= 1'b1;
                     addr_q  <= write_ecall_addr;
                     state_q <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               rd_en_q <= 1'b0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               txd_q   <= mem_rd_data;
               txv_q   <= 1'b1;
               state_q <= S_SEND;
            end
            S_SEND: begin
               if (tx_ready) begin
                  txv_q  <= 1'b0;
                  off_q  <= off_d;
                  sent_q <= sent_q + 1'b1;
                  if (off_d == len_q) begin
                     fin_q   <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     rd_en_q <= 1'b1;
                     addr_q  <= base_q + off_d;
                     state_q <= S_FETCH;
                  end
               end
            end
            S_DONE: begin
               // a request still held high must not restart the transfer
               fin_q <= 1'b1;
               if (!write_ecall) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign finished   = fin_q;
   assign mem_rd_en  = rd_en_q;
   assign mem_addr   = addr_q;
   assign tx_data    = txd_q;
   assign tx_valid   = txv_q;
   assign bad_fd     = bad_q;
   assign bytes_sent = sent_q;

endmodule

// File: tb/tb_ecall_write_sequencer.sv
// Self-checking bench for ecall_write_sequencer: vector table,
// hand-written corner sequences and randomized transfers.
module tb_ecall_write_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        write_ecall;
   logic [31:0] write_ecall_fd;
   logic [31:0] write_ecall_addr;
   logic [31:0] write_ecall_len;
   logic        finished;
   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic [7:0]  mem_rd_data = 8'h00;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        bad_fd;
   logic [31:0] bytes_sent;

   always #5 clk = ~clk;

   ecall_write_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .write_ecall      (write_ecall),
      .write_ecall_fd   (write_ecall_fd),
      .write_ecall_addr (write_ecall_addr),
      .write_ecall_len  (write_ecall_len),
      .finished         (finished),
      .mem_rd_en        (mem_rd_en),
      .mem_addr         (mem_addr),
      .mem_rd_data      (mem_rd_data),
      .tx_data          (tx_data),
      .tx_valid         (tx_valid),
      .tx_ready         (tx_ready),
      .bad_fd           (bad_fd),
      .bytes_sent       (bytes_sent)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0]  mem [logic [31:0]];
   logic [31:0] addr_log[$];
   logic [7:0]  data_log[$];
   int          rdy_mode = 0;
   int          stall_n  = 0;
   bit          bad_model;

   typedef struct {
      logic [31:0] fd;
      logic [31:0] addr;
      logic [31:0] len;
      int          exp_cyc;
      logic [31:0] exp_sent;
      bit          exp_bad;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
   endfunction

   // memory port 2 read: data one cycle after the enable
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem_byte(mem_addr);
   end

   // link side: 1 = random ready, 2 = 4-cycle stall on the second byte
   always @(posedge clk) begin
      #1;
      if (rdy_mode == 1) begin
         tx_ready = 1'($urandom_range(0, 1));
      end else if (rdy_mode == 2) begin
         if (tx_valid && data_log.size() == 1 && stall_n < 4) begin
            tx_ready = 1'b0;
            stall_n++;
         end else begin
            tx_ready = 1'b1;
         end
      end
   end

   logic       pv = 1'b0;
   logic       pr = 1'b0;
   logic       pe = 1'b0;
   logic [7:0] pd = 8'h00;

   always @(negedge clk) begin
      if (rst) begin
         if (mem_rd_en) addr_log.push_back(mem_addr);
         if (tx_valid && tx_ready) data_log.push_back(tx_data);
         if (pv && !pr) begin
            check("tx_hold_valid", 32'(tx_valid), 32'd1);
            check("tx_hold_data", 32'(tx_data), 32'(pd));
         end
         if (pe) check("rd_en_single", 32'(mem_rd_en), 32'd0);
      end
      pv <= tx_valid;
      pr <= tx_ready;
      pd <= tx_data;
      pe <= mem_rd_en && rst;
   end

   task automatic run_txn(input logic [31:0] fd, input logic [31:0] a,
                          input logic [31:0] len, input int mode,
                          input int exp_cyc, input logic [31:0] exp_sent,
                          input bit exp_bad, input bit drop);
      int          cyc;
      bit          ok;
      logic [31:0] n;
      ok = (fd == 32'd1) || (fd == 32'd2);
      n  = ok ? len : 32'd0;
      addr_log.delete();
      data_log.delete();
      stall_n  = 0;
      rdy_mode = mode;
      if (mode == 0) tx_ready = 1'b1;
      write_ecall      = 1'b1;
      write_ecall_fd   = fd;
      write_ecall_addr = a;
      write_ecall_len  = len;
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 1) begin
            check("fin_low_after_accept", 32'(finished), 32'd0);
            write_ecall_fd   = $urandom;
            write_ecall_addr = $urandom;
            write_ecall_len  = $urandom;
         end
         if (drop && cyc == 3) write_ecall = 1'b0;
      end while (!(cyc > 1 && finished) && cyc < 3000);
      check("finish_seen", 32'(finished), 32'd1);
      if (exp_cyc >= 0) check("latency", 32'(cyc - 1), 32'(exp_cyc));
      repeat (3) @(posedge clk);
      #1;
      check("fin_held", 32'(finished), 32'd1);
      check("bytes_sent", bytes_sent, exp_sent);
      check("bad_fd", 32'(bad_fd), 32'(exp_bad));
      check("rd_count", 32'(addr_log.size()), n);
      for (int i = 0; i < int'(n) && i < addr_log.size(); i++)
         check("rd_addr", addr_log[i], a + 32'(i));
      check("tx_count", 32'(data_log.size()), n);
      for (int i = 0; i < int'(n) && i < data_log.size(); i++)
         check("tx_byte", 32'(data_log[i]), 32'(mem_byte(a + 32'(i))));
      write_ecall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int          w;
      bit          ok;
      logic [31:0] fd;
      logic [31:0] a;
      logic [31:0] len;
      int          mode;

      rst              = 1'b0;
      write_ecall      = 1'b0;
      write_ecall_fd   = '0;
      write_ecall_addr = '0;
      write_ecall_len  = '0;
      tx_ready         = 1'b0;
      bad_model        = 1'b0;
      mem[32'h100] = 8'h41;
      mem[32'h101] = 8'h42;
      mem[32'h102] = 8'h43;

      tbl[0] = '{32'd1,  32'h100,      32'd3, 9, 32'd3, 1'b0};
      tbl[1] = '{32'd1,  32'h200,      32'd0, 1, 32'd0, 1'b0};
      tbl[2] = '{32'd2,  32'h300,      32'd1, 3, 32'd1, 1'b0};
      tbl[3] = '{32'd5,  32'h100,      32'd3, 1, 32'd0, 1'b1};
      tbl[4] = '{32'd1,  32'h100,      32'd3, 9, 32'd3, 1'b1};
      tbl[5] = '{32'd1,  32'hFFFFFFFF, 32'd2, 6, 32'd2, 1'b1};
      tbl[6] = '{32'd33, 32'h10,       32'd4, 1, 32'd0, 1'b1};
      tbl[7] = '{32'd0,  32'h20,       32'd1, 1, 32'd0, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      check("rst_finished", 32'(finished), 32'd1);
      check("rst_rd_en", 32'(mem_rd_en), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_bad_fd", 32'(bad_fd), 32'd0);
      check("rst_bytes_sent", bytes_sent, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i])
         run_txn(tbl[i].fd, tbl[i].addr, tbl[i].len, 0, tbl[i].exp_cyc,
                 tbl[i].exp_sent, tbl[i].exp_bad, 1'b0);

      // second byte stalled 4 cycles: 4 * 3 + 4 cycles to finish
      run_txn(32'd1, 32'h400, 32'd4, 2, 16, 32'd4, 1'b1, 1'b0);

      // reset in the middle of the first SEND
      rdy_mode         = 0;
      tx_ready         = 1'b1;
      write_ecall      = 1'b1;
      write_ecall_fd   = 32'd1;
      write_ecall_addr = 32'h600;
      write_ecall_len  = 32'd8;
      w = 0;
      do begin
         @(posedge clk);
         #1;
         w++;
      end while (!tx_valid && w < 20);
      check("send_reached", 32'(tx_valid), 32'd1);
      rst         = 1'b0;
      write_ecall = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_finished", 32'(finished), 32'd1);
      check("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
      check("mid_rst_mem_addr", mem_addr, 32'd0);
      check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
      check("mid_rst_tx_data", 32'(tx_data), 32'd0);
      check("mid_rst_bad_fd", 32'(bad_fd), 32'd0);
      check("mid_rst_sent", bytes_sent, 32'd0);
      rst       = 1'b1;
      bad_model = 1'b0;
      @(posedge clk);
      #1;
      run_txn(32'd1, 32'h600, 32'd2, 0, 6, 32'd2, 1'b0, 1'b0);

      for (int k = 0; k < 25; k++) begin
         case ($urandom_range(0, 3))
            0:       fd = 32'd1;
            1:       fd = 32'd2;
            2:       fd = 32'($urandom_range(0, 7));
            default: fd = 32'd1;
         endcase
         if ($urandom_range(0, 1) == 1)
            a = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
         else
            a = $urandom;
         len  = 32'($urandom_range(0, 6));
         mode = int'($urandom_range(0, 1));
         ok   = (fd == 32'd1) || (fd == 32'd2);
         if (!ok) bad_model = 1'b1;
         run_txn(fd, a, len, mode,
                 (mode == 0) ? ((ok && len != 0) ? 3 * int'(len) : 1) : -1,
                 ok ? len : 32'd0, bad_model,
                 $urandom_range(0, 3) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
